ddr_req_queue: RTL and testbench

- Upstream feeder of the ACT sequencing stage.
- Accepts host memory requests (flat address + read/write), decodes each into bank group/bank/row/column, and buffers them in a FIFO.
- Dispatches one request at a time: drives mem_addr/rw and pulses act_cmd when the ACT stage is idle and the controller is in read/write processing.
- Holds the dispatched request stable until the ACT stage has consumed it and returned to idle.

---
 rtl/ddr_req_queue_pkg.sv | 38 +++
 rtl/ddr_req_queue_req_fifo.sv | 51 +++++
 rtl/ddr_req_queue.sv | 88 ++++++++
 tb/tb_ddr_req_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_req_queue_pkg.sv
// Shared types for the DDR request queue: address fields, rw encoding, FIFO
// entry layout and dispatch FSM states.
package ddr_package;

    localparam int RA_WIDTH = 15;
    localparam int CA_WIDTH = 10;
    localparam int BG_WIDTH = 2;
    localparam int BA_WIDTH = 2;
    localparam int FLAT_W   = RA_WIDTH + BG_WIDTH + BA_WIDTH + CA_WIDTH;

    localparam logic [1:0] READ  = 2'b00;
    localparam logic [1:0] WRITE = 2'b01;

    typedef struct packed {
        logic [BG_WIDTH-1:0] bg_addr;
        logic [BA_WIDTH-1:0] ba_addr;
        logic [RA_WIDTH-1:0] row_addr;
        logic [CA_WIDTH-1:0] col_addr;
    } mem_addr_type;

    typedef struct packed {
        logic [1:0]   rw;
        mem_addr_type addr;
    } dq_entry_type;

    typedef enum logic [1:0] {DQ_IDLE, DQ_ACCEPT, DQ_BUSY} dq_fsm_type;

    // Flat host address layout is {row, bg, ba, col}, MSB first.
    function automatic mem_addr_type decode_addr(input logic [FLAT_W-1:0] a);
        mem_addr_type m;
        m.col_addr = a[CA_WIDTH-1:0];
        m.ba_addr  = a[CA_WIDTH +: BA_WIDTH];
        m.bg_addr  = a[CA_WIDTH+BA_WIDTH +: BG_WIDTH];
        m.row_addr = a[FLAT_W-1 -: RA_WIDTH];
        return m;
    endfunction

endpackage

// File: rtl/ddr_req_queue_req_fifo.sv
// Generic synchronous FIFO; head entry is visible on dout while not empty.
module req_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the cleared pointers/count make old entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ddr_req_queue.sv
// Host request queue feeding the ACT stage: decode at push, one-at-a-time
// dispatch with an act_cmd re-pulse if the ACT stage never leaves idle.
module ddr_req_queue
    import ddr_package::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 29,
    parameter int ACCEPT_TO = 16
) (
    input  logic                    clock_t,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [1:0]              req_rw,
    output logic                    req_ready,
    input  logic                    act_idle,
    input  logic                    rw_proc,
    output logic                    act_cmd,
    output mem_addr_type            mem_addr,
    output logic [1:0]              rw,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    q_empty
);

    localparam int TW = $clog2(ACCEPT_TO + 1);

    dq_fsm_type    state;
    logic [TW-1:0] to_cnt;
    dq_entry_type  push_entry, head;
    logic          fifo_full, push, pop;

    assign push_entry.rw   = req_rw;
    assign push_entry.addr = decode_addr(req_addr);
    assign req_ready       = !fifo_full;
    assign push            = req_valid && req_ready;
    assign pop             = (state == DQ_IDLE) && !q_empty && act_idle && rw_proc;

    req_fifo #(.DEPTH(DEPTH), .T(dq_entry_type)) u_fifo (
        .clk   (clock_t),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .count (q_count),
        .full  (fifo_full),
        .empty (q_empty)
    );

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state    <= DQ_IDLE;
            to_cnt   <= '0;
            act_cmd  <= 1'b0;
            mem_addr <= '0;
            rw       <= READ;
        end else begin
            act_cmd <= 1'b0;
            case (state)
                DQ_IDLE: begin
                    if (pop) begin
                        mem_addr <= head.addr;
                        rw       <= head.rw;
                        act_cmd  <= 1'b1;
                        to_cnt   <= '0;
                        state    <= DQ_ACCEPT;
                    end
                end
                DQ_ACCEPT: begin
                    if (!act_idle) begin
                        state <= DQ_BUSY;
                    end else if (to_cnt == TW'(ACCEPT_TO - 1)) begin
                        // ACT stage missed the pulse (e.g. rw_proc dropped); offer it again.
                        act_cmd <= 1'b1;
                        to_cnt  <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                DQ_BUSY: begin
                    if (act_idle) state <= DQ_IDLE;
                end
                default: state <= DQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_req_queue.sv
// Directed bench for ddr_req_queue: dispatch order, hold, timeout re-pulse,
// full-queue pop/push interaction and asynchronous reset.
module tb_ddr_req_queue;
    import ddr_package::*;

    logic         clock_t, reset_n, req_valid, req_ready, act_idle, rw_proc;
    logic [28:0]  req_addr;
    logic [1:0]   req_rw, rw;
    logic         act_cmd, q_empty;
    mem_addr_type mem_addr;
    logic [3:0]   q_count;

    int n_checks = 0;
    int n_pass   = 0;

    ddr_req_queue #(.DEPTH(8), .ADDR_W(29), .ACCEPT_TO(16)) dut (
        .clock_t  (clock_t),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_rw   (req_rw),
        .req_ready(req_ready),
        .act_idle (act_idle),
        .rw_proc  (rw_proc),
        .act_cmd  (act_cmd),
        .mem_addr (mem_addr),
        .rw       (rw),
        .q_count  (q_count),
        .q_empty  (q_empty)
    );

    initial clock_t = 1'b0;
    always #5 clock_t = ~clock_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_t);
        #1;
    endtask

    function automatic mem_addr_type mk(input logic [14:0] r, input logic [1:0] g,
                                        input logic [1:0] b, input logic [9:0] c);
        mem_addr_type m;
        m.row_addr = r; m.bg_addr = g; m.ba_addr = b; m.col_addr = c;
        return m;
    endfunction

    task automatic push_one(input mem_addr_type m, input logic [1:0] d);
        req_addr  = {m.row_addr, m.bg_addr, m.ba_addr, m.col_addr};
        req_rw    = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = READ;
        act_idle = 1'b1; rw_proc = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_rw = WRITE;
        act_idle = 1'b1; rw_proc = 1'b1;
        #3;
        n_checks++;
        if (act_cmd !== 1'b0 || mem_addr !== '0 || rw !== READ || q_count !== 4'd0 ||
            q_empty !== 1'b1 || req_ready !== 1'b1)
            $display("FAIL reset_state: act_cmd=%b mem_addr=%h rw=%b q_count=%0d q_empty=%b req_ready=%b, want 0/0/00/0/1/1",
                     act_cmd, mem_addr, rw, q_count, q_empty, req_ready);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (act_cmd !== 1'b0 || q_empty !== 1'b1)
            $display("FAIL reset_idle_no_dispatch: act_cmd=%b q_empty=%b, want 0/1", act_cmd, q_empty);
        else n_pass++;
    endtask

    task automatic test_single();
        mem_addr_type exp_m;
        do_reset();
        act_idle = 1'b1; rw_proc = 1'b1;
        req_addr = 29'h0_1234_ABC; req_rw = READ; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (act_cmd !== 1'b0 || q_count !== 4'd1)
            $display("FAIL single_after_push: act_cmd=%b q_count=%0d, want 0/1", act_cmd, q_count);
        else n_pass++;
        tick();
        exp_m = mk(15'h048D, 2'b00, 2'b10, 10'h2BC);
        n_checks++;
        if (act_cmd !== 1'b1 || mem_addr !== exp_m || rw !== READ || q_count !== 4'd0)
            $display("FAIL single_dispatch: act_cmd=%b mem_addr=%h rw=%b q_count=%0d, want 1/%h/00/0",
                     act_cmd, mem_addr, rw, q_count, exp_m);
        else n_pass++;
        act_idle = 1'b0;
        tick();
        n_checks++;
        if (act_cmd !== 1'b0)
            $display("FAIL single_pulse_width: act_cmd=%b, want 0", act_cmd);
        else n_pass++;
        act_idle = 1'b1;
        tick();
    endtask

    task automatic test_fill_dispatch();
        mem_addr_type exp_m [9];
        logic [1:0]   exp_rw [9];
        int           extra;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            exp_m[i]  = mk(15'(32'h100 + i), 2'(i), 2'(3 - (i % 4)), 10'(1023 - i));
            exp_rw[i] = (i % 2 == 0) ? WRITE : READ;
        end
        for (int i = 0; i < 9; i++) begin
            push_one(exp_m[i], exp_rw[i]);
            if (i == 7) begin
                n_checks++;
                if (req_ready !== 1'b0 || q_count !== 4'd8)
                    $display("FAIL fill_full: req_ready=%b q_count=%0d, want 0/8", req_ready, q_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (q_count !== 4'd8 || act_cmd !== 1'b0)
            $display("FAIL fill_ninth_dropped: q_count=%0d act_cmd=%b, want 8/0", q_count, act_cmd);
        else n_pass++;
        rw_proc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int w = 0;
            while (act_cmd !== 1'b1 && w < 10) begin tick(); w++; end
            n_checks++;
            if (w >= 10 || mem_addr !== exp_m[k] || rw !== exp_rw[k])
                $display("FAIL fill_order[%0d]: act_cmd=%b mem_addr=%h rw=%b, want 1/%h/%b",
                         k, act_cmd, mem_addr, rw, exp_m[k], exp_rw[k]);
            else n_pass++;
            act_idle = 1'b0;
            tick();
            tick();
            act_idle = 1'b1;
            tick();
        end
        extra = 0;
        for (int t = 0; t < 20; t++) begin
            if (act_cmd === 1'b1) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0 || q_empty !== 1'b1)
            $display("FAIL fill_no_extra: extra_pulses=%0d q_empty=%b, want 0/1", extra, q_empty);
        else n_pass++;
    endtask

    task automatic test_hold();
        mem_addr_type e0, e1;
        do_reset();
        e0 = mk(15'h7FFF, 2'b11, 2'b01, 10'h001);
        e1 = mk(15'h0001, 2'b01, 2'b11, 10'h3FE);
        push_one(e0, WRITE);
        push_one(e1, READ);
        rw_proc = 1'b1;
        tick();
        n_checks++;
        if (act_cmd !== 1'b1 || mem_addr !== e0 || rw !== WRITE)
            $display("FAIL hold_dispatch: act_cmd=%b mem_addr=%h rw=%b, want 1/%h/01", act_cmd, mem_addr, rw, e0);
        else n_pass++;
        act_idle = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (act_cmd !== 1'b0 || mem_addr !== e0 || rw !== WRITE)
                $display("FAIL hold_stable[%0d]: act_cmd=%b mem_addr=%h rw=%b, want 0/%h/01", c, act_cmd, mem_addr, rw, e0);
            else n_pass++;
        end
        act_idle = 1'b1;
        tick();
        n_checks++;
        if (act_cmd !== 1'b0 || mem_addr !== e0)
            $display("FAIL hold_no_early: act_cmd=%b mem_addr=%h, want 0/%h", act_cmd, mem_addr, e0);
        else n_pass++;
        tick();
        n_checks++;
        if (act_cmd !== 1'b1 || mem_addr !== e1 || rw !== READ)
            $display("FAIL hold_next: act_cmd=%b mem_addr=%h rw=%b, want 1/%h/00", act_cmd, mem_addr, rw, e1);
        else n_pass++;
    endtask

    task automatic test_timeout();
        mem_addr_type e0, e1;
        int bad;
        do_reset();
        e0 = mk(15'h2AAA, 2'b10, 2'b01, 10'h155);
        e1 = mk(15'h1555, 2'b01, 2'b10, 10'h2AA);
        push_one(e0, READ);
        push_one(e1, WRITE);
        rw_proc = 1'b1;
        tick();
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            n_checks++;
            if (act_cmd !== ((t % 16) == 0) || mem_addr !== e0 || q_count !== 4'd1) begin
                $display("FAIL timeout_cycle[%0d]: act_cmd=%b mem_addr=%h q_count=%0d, want %b/%h/1",
                         t, act_cmd, mem_addr, q_count, (t % 16) == 0, e0);
                bad++;
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_full_pop();
        mem_addr_type e;
        do_reset();
        for (int i = 0; i < 8; i++) push_one(mk(15'(i), 2'b00, 2'b00, 10'(i)), READ);
        n_checks++;
        if (q_count !== 4'd8 || req_ready !== 1'b0)
            $display("FAIL fullpop_full: q_count=%0d req_ready=%b, want 8/0", q_count, req_ready);
        else n_pass++;
        e = mk(15'h0ABC, 2'b11, 2'b11, 10'h0CC);
        req_addr = {e.row_addr, e.bg_addr, e.ba_addr, e.col_addr};
        req_rw = WRITE; req_valid = 1'b1; rw_proc = 1'b1;
        tick();
        n_checks++;
        if (q_count !== 4'd7 || act_cmd !== 1'b1 || req_ready !== 1'b1)
            $display("FAIL fullpop_pop_only: q_count=%0d act_cmd=%b req_ready=%b, want 7/1/1", q_count, act_cmd, req_ready);
        else n_pass++;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (q_count !== 4'd8)
            $display("FAIL fullpop_push_next: q_count=%0d, want 8", q_count);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        mem_addr_type e;
        int pulses, w;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(mk(15'(100 + i), 2'b01, 2'b01, 10'(i)), WRITE);
        rw_proc = 1'b1;
        tick();
        act_idle = 1'b0;
        tick();
        n_checks++;
        if (q_count !== 4'd3)
            $display("FAIL rstbusy_pre: q_count=%0d, want 3", q_count);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (act_cmd !== 1'b0 || q_count !== 4'd0 || req_ready !== 1'b1 || q_empty !== 1'b1 || mem_addr !== '0)
            $display("FAIL rstbusy_async: act_cmd=%b q_count=%0d req_ready=%b q_empty=%b mem_addr=%h, want 0/0/1/1/0",
                     act_cmd, q_count, req_ready, q_empty, mem_addr);
        else n_pass++;
        tick();
        reset_n = 1'b1; act_idle = 1'b1; rw_proc = 1'b1;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (act_cmd === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0)
            $display("FAIL rstbusy_no_dispatch: pulses=%0d, want 0", pulses);
        else n_pass++;
        e = mk(15'h0321, 2'b10, 2'b00, 10'h111);
        push_one(e, READ);
        w = 0;
        while (act_cmd !== 1'b1 && w < 10) begin tick(); w++; end
        n_checks++;
        if (w >= 10 || mem_addr !== e || rw !== READ)
            $display("FAIL rstbusy_new_push: act_cmd=%b mem_addr=%h rw=%b, want 1/%h/00", act_cmd, mem_addr, rw, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_dispatch();
        test_hold();
        test_timeout();
        test_full_pop();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
